deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deser_if.sv | 21 ++
 rtl/deserializer.sv | 130 +++++++++++++
 tb/tb_deserializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/deser_if.sv
// Serial-in / parallel-out bundle for the deserializer.
// The master drives the serial bits and the slave returns words, strobes and status.
interface deser_if;
    logic        ser_data_i;
    logic        ser_data_val_i;
    logic [15:0] deser_data_o;
    logic [4:0]  deser_len_o;
    logic        deser_data_val_o;
    logic        deser_err_o;
    logic        busy_o;

    modport master (
        output ser_data_i, ser_data_val_i,
        input  deser_data_o, deser_len_o, deser_data_val_o, deser_err_o, busy_o
    );

    modport slave (
        input  ser_data_i, ser_data_val_i,
        output deser_data_o, deser_len_o, deser_data_val_o, deser_err_o, busy_o
    );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial burst deserializer producing left-aligned 16-bit words with length.
// Define DESER_LEN_CHECK_EN to drop bursts shorter than MIN_LEN and flag them on deser_err_o.
module deserializer #(
    parameter int MIN_LEN = 3
) (
    input  logic  clk_i,
    input  logic  arst_ni,
    deser_if.slave bus
);

`ifdef DESER_LEN_CHECK_EN
    localparam bit LEN_CHECK_C = 1'b1;
`else
    localparam bit LEN_CHECK_C = 1'b0;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] data_q, data_d;
    logic [4:0]  len_q, len_d;
    logic        val_q, val_d;
    logic        err_q, err_d;

    logic        emit_s;
    logic        short_s;
    logic [15:0] emit_word_s;
    logic [4:0]  emit_len_s;
    logic [3:0]  pos_s;

    // In RECV count is 1..15, so the next bit position 15-count is the 4-bit complement.
    assign pos_s = ~cnt_q[3:0];

    // Next-state, shift-register and word-completion decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        emit_s      = 1'b0;
        emit_word_s = shift_q;
        emit_len_s  = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.ser_data_val_i) begin
                    shift_d = {bus.ser_data_i, 15'h0000};
                    cnt_d   = 5'd1;
                    state_d = RECV;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (bus.ser_data_val_i) begin
                    shift_d[pos_s] = bus.ser_data_i;
                    if (cnt_q == 5'd15) begin
                        emit_s      = 1'b1;
                        emit_word_s = shift_d;
                        emit_len_s  = 5'd16;
                        cnt_d       = 5'd0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    emit_s  = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    assign short_s = LEN_CHECK_C && (emit_len_s < 5'(MIN_LEN));

    // Output word/strobe selection; a short burst turns its strobe into an error pulse.
    always_comb begin
        val_d  = 1'b0;
        err_d  = 1'b0;
        data_d = data_q;
        len_d  = len_q;
        if (emit_s) begin
            if (short_s) begin
                err_d = 1'b1;
            end else begin
                val_d  = 1'b1;
                data_d = emit_word_s;
                len_d  = emit_len_s;
            end
        end else begin
            val_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            shift_q <= 16'h0000;
            data_q  <= 16'h0000;
            len_q   <= 5'd0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            len_q   <= len_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    assign bus.deser_data_o     = data_q;
    assign bus.deser_len_o      = len_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.deser_err_o      = err_q;
    assign bus.busy_o           = (state_q == RECV);

endmodule

// File: tb/tb_deserializer.sv
// Randomized plus directed bench for deserializer, checked cycle by cycle against a
// queue-based burst model; honours DESER_LEN_CHECK_EN the same way the design does.
module tb_deserializer;

`ifdef DESER_LEN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int MIN_LEN = 3;

    logic clk;
    logic arst_n;
    deser_if bus ();

    deserializer #(.MIN_LEN(MIN_LEN)) dut (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state: bits of the burst in progress and expected registered outputs.
    int          q[$];
    logic        exp_val, exp_err, exp_busy;
    logic [15:0] exp_data;
    logic [4:0]  exp_len;

    // Observations collected for directed checks.
    int          strobe_cyc[$];
    logic [15:0] strobe_word[$];
    logic [4:0]  strobe_len[$];
    int          err_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_emit();
        int w;
        int n;
        w = 0;
        n = q.size();
        for (int i = 0; i < n; i++) w = w + q[i] * (1 << (15 - i));
        if (CHK_EN && n < MIN_LEN) begin
            exp_err = 1'b1;
        end else begin
            exp_val  = 1'b1;
            exp_data = w[15:0];
            exp_len  = n[4:0];
        end
        q.delete();
    endtask

    task automatic model_step(input logic v, input logic b);
        exp_val = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            q.push_back(b ? 1 : 0);
            if (q.size() == 16) model_emit();
        end else if (q.size() > 0) begin
            model_emit();
        end
        exp_busy = (q.size() > 0);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".val"},  32'(bus.deser_data_val_o), 32'(exp_val));
        check_eq({tag, ".err"},  32'(bus.deser_err_o),      32'(exp_err));
        check_eq({tag, ".data"}, 32'(bus.deser_data_o),     32'(exp_data));
        check_eq({tag, ".len"},  32'(bus.deser_len_o),      32'(exp_len));
        check_eq({tag, ".busy"}, 32'(bus.busy_o),           32'(exp_busy));
        if (bus.deser_data_val_o && bus.deser_err_o)
            check_eq({tag, ".excl"}, 32'd1, 32'd0);
    endtask

    task automatic step(input logic v, input logic b);
        @(negedge clk);
        bus.ser_data_val_i = v;
        bus.ser_data_i     = b;
        model_step(v, b);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs("cyc");
        if (bus.deser_data_val_o) begin
            strobe_cyc.push_back(cyc);
            strobe_word.push_back(bus.deser_data_o);
            strobe_len.push_back(bus.deser_len_o);
        end
        if (bus.deser_err_o) err_seen++;
    endtask

    task automatic send_bits(input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, word[i]);
    endtask

    task automatic clear_obs();
        strobe_cyc.delete();
        strobe_word.delete();
        strobe_len.delete();
        err_seen = 0;
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        bus.ser_data_val_i = 1'b0;
        #1;
        q.delete();
        exp_val = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_data = 16'h0000; exp_len = 5'd0;
        check_outputs("rst");
        repeat (hold) @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0;
        bus.ser_data_i = 1'b0;
        bus.ser_data_val_i = 1'b0;
        q.delete();
        exp_val = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_data = 16'h0000; exp_len = 5'd0;
        #1;
        check_outputs("por");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        step(1'b0, 1'b0);

        // Full 16-bit word then idle.
        clear_obs();
        send_bits(32'h0000A5C3, 16);
        step(1'b0, 1'b0);
        check_eq("a5c3.n", strobe_word.size(), 1);
        if (strobe_word.size() == 1) begin
            check_eq("a5c3.word", 32'(strobe_word[0]), 32'h0000A5C3);
            check_eq("a5c3.len", 32'(strobe_len[0]), 32'd16);
        end

        // Five-bit burst 1,0,1,1,0.
        clear_obs();
        send_bits(32'h16, 5);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("b5.n", strobe_word.size(), 1);
        if (strobe_word.size() == 1) begin
            check_eq("b5.word", 32'(strobe_word[0]), 32'h0000B000);
            check_eq("b5.len", 32'(strobe_len[0]), 32'd5);
        end

        // Back-to-back 16-bit words, 32 contiguous bits.
        clear_obs();
        send_bits(32'h1234FFFF, 32);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("b2b.n", strobe_word.size(), 2);
        if (strobe_word.size() == 2) begin
            check_eq("b2b.gap", strobe_cyc[1] - strobe_cyc[0], 16);
            check_eq("b2b.w0", 32'(strobe_word[0]), 32'h00001234);
            check_eq("b2b.w1", 32'(strobe_word[1]), 32'h0000FFFF);
            check_eq("b2b.l1", 32'(strobe_len[1]), 32'd16);
        end

        // Two-bit burst: short-burst error or plain emission depending on build.
        clear_obs();
        send_bits(32'h3, 2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        if (CHK_EN) begin
            check_eq("short.n", strobe_word.size(), 0);
            check_eq("short.err", err_seen, 1);
            check_eq("short.hold", 32'(bus.deser_data_o), 32'h0000FFFF);
        end else begin
            check_eq("short.n", strobe_word.size(), 1);
            check_eq("short.err", err_seen, 0);
            if (strobe_len.size() == 1) check_eq("short.len", 32'(strobe_len[0]), 32'd2);
        end

        // Reset after 7 bits of a burst, then a 3-bit burst 1,1,1.
        clear_obs();
        send_bits(32'h55, 7);
        apply_reset(2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("abort.n", strobe_word.size(), 0);
        send_bits(32'h7, 3);
        step(1'b0, 1'b0);
        check_eq("abort.n2", strobe_word.size(), 1);
        if (strobe_word.size() == 1) begin
            check_eq("abort.word", 32'(strobe_word[0]), 32'h0000E000);
            check_eq("abort.len", 32'(strobe_len[0]), 32'd3);
        end

        // Two 4-bit bursts separated by a one-cycle gap.
        clear_obs();
        send_bits(32'hF, 4);
        step(1'b0, 1'b0);
        send_bits(32'h0, 4);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("gap.n", strobe_word.size(), 2);
        if (strobe_word.size() == 2) begin
            check_eq("gap.w0", 32'(strobe_word[0]), 32'h0000F000);
            check_eq("gap.w1", 32'(strobe_word[1]), 32'h00000000);
            check_eq("gap.l1", 32'(strobe_len[1]), 32'd4);
        end

        // Random traffic: mixed burst lengths, occasional overlong bursts and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset(1);
            end else begin
                step(($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            end
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
